// File: rtl/fc_stream_layer_if.sv
// Bundle of weight-load, streaming input, streaming output and status signals
// for fc_stream_layer. The testbench or upstream logic uses the master side.
interface fc_stream_layer_if #(
    parameter int DATA_W    = 32,
    parameter int IN_IDX_W  = 10,
    parameter int OUT_IDX_W = 4
);
    // Handshake: a beat moves on the rising clk edge where valid && ready are both
    // high; the source holds data/idx/last stable while valid && !ready.
    logic                 wt_load;
    logic                 bias_load;
    logic [OUT_IDX_W-1:0] wt_row;
    logic [IN_IDX_W-1:0]  wt_col;
    logic [DATA_W-1:0]    wt_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic [OUT_IDX_W-1:0] out_idx;
    logic                 out_last;
    logic                 busy;
    logic                 seq_err;

    modport master (
        output wt_load, bias_load, wt_row, wt_col, wt_data,
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy, seq_err
    );

    modport slave (
        input  wt_load, bias_load, wt_row, wt_col, wt_data,
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy, seq_err
    );
endinterface

// File: rtl/fc_stream_layer.sv
// Streaming fully-connected layer: one input element per beat updates every
// neuron's accumulator, then biased, saturated, optionally rectified outputs drain.
module fc_stream_layer #(
    parameter int IN_DIM    = 1024,
    parameter int OUT_DIM   = 10,
    parameter int IN_IDX_W  = 10,
    parameter int OUT_IDX_W = 4,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16,
    parameter int ACC_W     = 56,
    parameter int RELU_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    fc_stream_layer_if.slave bus,
    output logic             dbg_drain_o
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam logic [IN_IDX_W-1:0]      LAST_BEAT = IN_IDX_W'(IN_DIM - 1);
    localparam logic [OUT_IDX_W-1:0]     LAST_OUT  = OUT_IDX_W'(OUT_DIM - 1);
    localparam logic signed [DATA_W-1:0] D_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN     = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   weight_q [OUT_DIM][IN_DIM];
    logic signed [DATA_W-1:0]   bias_q   [OUT_DIM];
    logic signed [ACC_W-1:0]    acc_q    [OUT_DIM];
    logic signed [ACC_W-1:0]    acc_d    [OUT_DIM];
    logic signed [PROD_W-1:0]   prod     [OUT_DIM];
    logic [IN_IDX_W-1:0]        in_cnt_q, in_cnt_d;
    logic [OUT_IDX_W-1:0]       out_idx_q, out_idx_d;
    logic [DATA_W-1:0]          out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;
    logic                       seq_err_q, seq_err_d;
    logic signed [SUM_W-1:0]    sum;
    logic                       busy, beat, cnt_end, row_ok, col_ok;

    function automatic logic [DATA_W-1:0] activate(input logic signed [SUM_W-1:0] s);
        logic [DATA_W-1:0] r;
        if (s > SUM_W'(D_MAX))      r = D_MAX;
        else if (s < SUM_W'(D_MIN)) r = D_MIN;
        else                        r = s[DATA_W-1:0];
        if (RELU_EN != 0 && r[DATA_W-1]) r = '0;
        return r;
    endfunction

    assign busy    = (in_cnt_q != '0) || (state_q == DRAIN);
    assign beat    = bus.in_valid && (state_q == ACCUM);
    assign cnt_end = (in_cnt_q == LAST_BEAT);
    assign row_ok  = {1'b0, bus.wt_row} < (OUT_IDX_W + 1)'(OUT_DIM);
    assign col_ok  = {1'b0, bus.wt_col} < (IN_IDX_W + 1)'(IN_DIM);

    always_comb begin
        for (int o = 0; o < OUT_DIM; o++)
            prod[o] = PROD_W'(weight_q[o][in_cnt_q]) * PROD_W'($signed(bus.in_data));
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_idx_d = out_idx_q;
        seq_err_d = 1'b0;
        for (int o = 0; o < OUT_DIM; o++) acc_d[o] = acc_q[o];

        case (state_q)
            ACCUM: begin
                if (beat) begin
                    if (bus.in_last && !cnt_end) begin
                        // Early in_last: drop the partial frame and start over.
                        seq_err_d = 1'b1;
                        in_cnt_d  = '0;
                        for (int o = 0; o < OUT_DIM; o++) acc_d[o] = '0;
                    end else begin
                        for (int o = 0; o < OUT_DIM; o++)
                            acc_d[o] = acc_q[o] + ACC_W'(prod[o] >>> FRAC_BITS);
                        if (cnt_end) begin
                            in_cnt_d  = '0;
                            out_idx_d = '0;
                            state_d   = DRAIN;
                            seq_err_d = !bus.in_last;
                        end else begin
                            in_cnt_d = in_cnt_q + IN_IDX_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (out_idx_q == LAST_OUT) begin
                        state_d   = ACCUM;
                        out_idx_d = '0;
                        for (int o = 0; o < OUT_DIM; o++) acc_d[o] = '0;
                    end else begin
                        out_idx_d = out_idx_q + OUT_IDX_W'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase

        // Reading acc_d lets the first output register on the same edge as the last beat.
        sum        = SUM_W'(acc_d[out_idx_d]) + SUM_W'(bias_q[out_idx_d]);
        out_data_d = (state_d == DRAIN) ? activate(sum) : '0;
        out_last_d = (state_d == DRAIN) && (out_idx_d == LAST_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            in_cnt_q   <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            seq_err_q  <= 1'b0;
            for (int o = 0; o < OUT_DIM; o++) begin
                acc_q[o]  <= '0;
                bias_q[o] <= '0;
                for (int i = 0; i < IN_DIM; i++) weight_q[o][i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            seq_err_q  <= seq_err_d;
            for (int o = 0; o < OUT_DIM; o++) acc_q[o] <= acc_d[o];
            // Coefficients only change between frames; a same-cycle beat sees the old value.
            if (bus.wt_load && !busy && row_ok && col_ok)
                weight_q[bus.wt_row][bus.wt_col] <= bus.wt_data;
            if (bus.bias_load && !busy && row_ok)
                bias_q[bus.wt_row] <= bus.wt_data;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy;
    assign bus.seq_err   = seq_err_q;
    assign dbg_drain_o   = (state_q == DRAIN);
endmodule

// File: tb/tb_fc_stream_layer.sv
// Bench for fc_stream_layer: two instances (ReLU off / on) share one stimulus
// stream; a reference model fills expected queues that the output monitor drains.
module tb_fc_stream_layer;
  localparam int IN_DIM    = 4;
  localparam int OUT_DIM   = 3;
  localparam int IN_IDX_W  = 3;
  localparam int OUT_IDX_W = 2;
  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 16;
  localparam int ACC_W     = 56;
  localparam int EW        = 1 + OUT_IDX_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 wt_load = 1'b0, bias_load = 1'b0;
  logic [OUT_IDX_W-1:0] wt_row = '0;
  logic [IN_IDX_W-1:0]  wt_col = '0;
  logic [DATA_W-1:0]    wt_data = '0, in_data = '0;
  logic                 in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic                 dbg0, dbg1;

  fc_stream_layer_if #(.DATA_W(DATA_W), .IN_IDX_W(IN_IDX_W), .OUT_IDX_W(OUT_IDX_W)) if0 ();
  fc_stream_layer_if #(.DATA_W(DATA_W), .IN_IDX_W(IN_IDX_W), .OUT_IDX_W(OUT_IDX_W)) if1 ();

  assign if0.wt_load = wt_load;     assign if1.wt_load = wt_load;
  assign if0.bias_load = bias_load; assign if1.bias_load = bias_load;
  assign if0.wt_row = wt_row;       assign if1.wt_row = wt_row;
  assign if0.wt_col = wt_col;       assign if1.wt_col = wt_col;
  assign if0.wt_data = wt_data;     assign if1.wt_data = wt_data;
  assign if0.in_valid = in_valid;   assign if1.in_valid = in_valid;
  assign if0.in_data = in_data;     assign if1.in_data = in_data;
  assign if0.in_last = in_last;     assign if1.in_last = in_last;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  fc_stream_layer #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .IN_IDX_W(IN_IDX_W), .OUT_IDX_W(OUT_IDX_W),
                    .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W), .RELU_EN(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0), .dbg_drain_o(dbg0));
  fc_stream_layer #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .IN_IDX_W(IN_IDX_W), .OUT_IDX_W(OUT_IDX_W),
                    .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W), .RELU_EN(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1), .dbg_drain_o(dbg1));

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];
  logic [EW-1:0] got0, got1, e0, e1;
  logic [DATA_W-1:0] m_w [OUT_DIM][IN_DIM];
  logic [DATA_W-1:0] m_b [OUT_DIM];
  logic [DATA_W-1:0] xb [IN_DIM];
  logic [DATA_W-1:0] xs [IN_DIM];

  function automatic logic [DATA_W-1:0] model_out(input int o, input logic [DATA_W-1:0] x [IN_DIM], input bit relu);
    longint acc = 0;
    longint s;
    logic [DATA_W-1:0] r;
    for (int i = 0; i < IN_DIM; i++)
      acc += (longint'($signed(m_w[o][i])) * longint'($signed(x[i]))) >>> FRAC_BITS;
    s = acc + longint'($signed(m_b[o]));
    if (s > 64'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (s < -64'sd2147483648) r = 32'h8000_0000;
    else                           r = s[DATA_W-1:0];
    if (relu && r[DATA_W-1]) r = '0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_ready && if0.out_valid) begin
      got0 = {if0.out_last, if0.out_idx, if0.out_data};
      n_cmp++;
      if (exp0_q.size() == 0) begin
        n_err++; $display("FAIL out_norelu unexpected beat last/idx/data=%h", got0);
      end else begin
        e0 = exp0_q.pop_front();
        if (got0 !== e0) begin n_err++; $display("FAIL out_norelu last/idx/data got=%h exp=%h", got0, e0); end
      end
    end
    if (!rst && out_ready && if1.out_valid) begin
      got1 = {if1.out_last, if1.out_idx, if1.out_data};
      n_cmp++;
      if (exp1_q.size() == 0) begin
        n_err++; $display("FAIL out_relu unexpected beat last/idx/data=%h", got1);
      end else begin
        e1 = exp1_q.pop_front();
        if (got1 !== e1) begin n_err++; $display("FAIL out_relu last/idx/data got=%h exp=%h", got1, e1); end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input bit w, input bit b, input int row, input int col, input logic [DATA_W-1:0] d, input bit track);
    wt_load = w; bias_load = b; wt_row = OUT_IDX_W'(row); wt_col = IN_IDX_W'(col); wt_data = d;
    tick();
    wt_load = 1'b0; bias_load = 1'b0;
    if (track && row < OUT_DIM) begin
      if (w && col < IN_DIM) m_w[row][col] = d;
      if (b) m_b[row] = d;
    end
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input bit last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!if0.in_ready && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 100) begin n_err++; $display("FAIL in_ready_timeout waited=%0d limit=100", n); end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push_expect(input logic [DATA_W-1:0] x [IN_DIM]);
    for (int o = 0; o < OUT_DIM; o++) begin
      exp0_q.push_back({(o == OUT_DIM - 1), OUT_IDX_W'(o), model_out(o, x, 1'b0)});
      exp1_q.push_back({(o == OUT_DIM - 1), OUT_IDX_W'(o), model_out(o, x, 1'b1)});
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] x [IN_DIM]);
    push_expect(x);
    for (int i = 0; i < IN_DIM; i++) send_beat(x[i], (i == IN_DIM - 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp0_q.size() != 0 || exp1_q.size() != 0 || if0.busy || if1.busy) && n < 200) begin
      @(negedge clk); n++;
    end
    n_cmp++;
    if (n >= 200) begin n_err++; $display("FAIL drain_timeout left0=%0d left1=%0d exp=0", exp0_q.size(), exp1_q.size()); end
    tick();
  endtask

  task automatic load_basic();
    for (int c = 0; c < IN_DIM; c++) begin
      load(1, 0, 0, c, 32'h0001_0000, 1);
      load(1, 0, 1, c, 32'h0000_8000, 1);
      load(1, 0, 2, c, 32'hFFFF_0000, 1);
    end
    load(0, 1, 0, 0, 32'h0, 1);
    load(0, 1, 1, 0, 32'h0000_4000, 1);
    load(0, 1, 2, 0, 32'h0, 1);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({if0.in_ready, if0.out_valid, if0.out_data, if0.out_idx, if0.out_last, if0.busy, if0.seq_err, dbg0} !==
        {1'b1, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_state_norelu rdy=%b vld=%b data=%h idx=%0d last=%b busy=%b err=%b exp 1/0/0/0/0/0/0",
                        if0.in_ready, if0.out_valid, if0.out_data, if0.out_idx, if0.out_last, if0.busy, if0.seq_err);
    end
    n_cmp++;
    if ({if1.in_ready, if1.out_valid, if1.out_data, if1.busy, if1.seq_err} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_state_relu rdy=%b vld=%b data=%h busy=%b err=%b exp 1/0/0/0/0",
                        if1.in_ready, if1.out_valid, if1.out_data, if1.busy, if1.seq_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_forward();
    load_basic();
    push_expect(xb);
    for (int i = 0; i < IN_DIM - 1; i++) send_beat(xb[i], 1'b0);
    n_cmp++;
    if (if0.out_valid !== 1'b0 || if0.busy !== 1'b1) begin
      n_err++; $display("FAIL pre_last_state vld=%b busy=%b exp vld=0 busy=1", if0.out_valid, if0.busy);
    end
    send_beat(xb[IN_DIM-1], 1'b1);
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 2'd0 || if0.in_ready !== 1'b0 || if0.seq_err !== 1'b0) begin
      n_err++; $display("FAIL first_out_latency vld=%b idx=%0d rdy=%b err=%b exp 1/0/0/0",
                        if0.out_valid, if0.out_idx, if0.in_ready, if0.seq_err);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] e_idx1;
    e_idx1 = model_out(1, xb, 1'b0);
    out_ready = 1'b1;
    send_frame(xb);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if0.out_valid !== 1'b1 || if0.out_idx !== 2'd1 || if0.out_data !== e_idx1 || if0.in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_hold cyc=%0d vld=%b idx=%0d data=%h rdy=%b exp 1/1/%h/0",
                          k, if0.out_valid, if0.out_idx, if0.out_data, if0.in_ready, e_idx1);
      end
    end
    tick();
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 2'd2 || if0.out_last !== 1'b1) begin
      n_err++; $display("FAIL post_stall_next vld=%b idx=%0d last=%b exp 1/2/1", if0.out_valid, if0.out_idx, if0.out_last);
    end
    wait_idle();
  endtask

  task automatic test_framing();
    send_beat(xb[0], 1'b0);
    send_beat(xb[1], 1'b1);
    n_cmp++;
    if (if0.seq_err !== 1'b1 || if1.seq_err !== 1'b1) begin
      n_err++; $display("FAIL abort_seq_err got=%b/%b exp=1/1", if0.seq_err, if1.seq_err);
    end
    tick();
    n_cmp++;
    if (if0.seq_err !== 1'b0 || if0.out_valid !== 1'b0 || if0.busy !== 1'b0 || if0.in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_after err=%b vld=%b busy=%b rdy=%b exp 0/0/0/1",
                        if0.seq_err, if0.out_valid, if0.busy, if0.in_ready);
    end
    send_frame(xb);
    wait_idle();
    // Frame that reaches IN_DIM beats without in_last: outputs still produced.
    push_expect(xb);
    for (int i = 0; i < IN_DIM; i++) send_beat(xb[i], 1'b0);
    n_cmp++;
    if (if0.seq_err !== 1'b1 || if0.out_valid !== 1'b1) begin
      n_err++; $display("FAIL missing_last err=%b vld=%b exp 1/1", if0.seq_err, if0.out_valid);
    end
    wait_idle();
  endtask

  task automatic test_saturation();
    for (int o = 0; o < OUT_DIM; o++) begin
      load(0, 1, o, 0, 32'h0, 1);
      for (int c = 0; c < IN_DIM; c++) load(1, 0, o, c, 32'h7FFF_0000, 1);
    end
    for (int i = 0; i < IN_DIM; i++) xs[i] = 32'h7FFF_0000;
    send_frame(xs);
    wait_idle();
    for (int i = 0; i < IN_DIM; i++) xs[i] = 32'h8001_0000;
    send_frame(xs);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] xa [IN_DIM];
    for (int o = 0; o < OUT_DIM; o++)
      for (int c = 0; c < IN_DIM; c++)
        load(1, 1, o, c, $urandom_range(0, 32'h0008_0000) - 32'h0004_0000, 1);
    load(1, 0, 3, 0, 32'h1234_0000, 1);
    load(1, 0, 0, 5, 32'h1234_0000, 1);
    for (int i = 0; i < IN_DIM; i++) begin
      xa[i] = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
      xs[i] = $urandom_range(0, 32'h0008_0000) - 32'h0004_0000;
    end
    fork
      begin send_frame(xa); send_frame(xs); end
      begin
        repeat (60) begin @(posedge clk); #2; out_ready = 1'($urandom_range(0, 1)); end
      end
    join
    out_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_loads();
    load_basic();
    push_expect(xb);
    send_beat(xb[0], 1'b0);
    wt_load = 1'b1; wt_row = 2'd0; wt_col = 3'd1; wt_data = 32'h0050_0000;
    send_beat(xb[1], 1'b0);
    wt_load = 1'b0;
    send_beat(xb[2], 1'b0);
    send_beat(xb[3], 1'b1);
    tick(); tick();
    out_ready = 1'b0; rst = 1'b1;
    exp0_q.delete(); exp1_q.delete();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.busy !== 1'b0 || if0.out_idx !== 2'd0 || dbg0 !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_drain vld=%b rdy=%b busy=%b idx=%0d exp 0/1/0/0",
                        if0.out_valid, if0.in_ready, if0.busy, if0.out_idx);
    end
    for (int o = 0; o < OUT_DIM; o++) begin
      m_b[o] = '0;
      for (int c = 0; c < IN_DIM; c++) m_w[o][c] = '0;
    end
    out_ready = 1'b1;
    send_frame(xb);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    xb[0] = 32'h0001_0000; xb[1] = 32'h0002_0000; xb[2] = 32'h0003_0000; xb[3] = 32'h0004_0000;
    for (int o = 0; o < OUT_DIM; o++) begin
      m_b[o] = '0;
      for (int c = 0; c < IN_DIM; c++) m_w[o][c] = '0;
    end
    test_reset();
    test_basic_forward();
    test_backpressure();
    test_framing();
    test_saturation();
    test_back_to_back();
    test_reset_loads();
    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fc_stream_layer.md
Name: fc_stream_layer

Overview:
- Parametrised fully-connected layer with streaming valid/ready input and output, signed Q-format arithmetic, per-output bias, saturation and optional ReLU.
- Inference-only successor of the team's fc block; sits between conv/pool stages and the classifier output.
- Weights and biases are loaded through a dedicated port between frames.
- Input order is checked by a beat counter rather than by watching index changes.

Parameters:
- IN_DIM, 1024, number of input elements per frame
- OUT_DIM, 10, number of outputs (neurons)
- IN_IDX_W, 10, width of input index (>= clog2(IN_DIM))
- OUT_IDX_W, 4, width of output index (>= clog2(OUT_DIM))
- DATA_W, 32, signed data/weight/bias width
- FRAC_BITS, 16, fractional bits (Q16.16 default)
- ACC_W, 56, signed accumulator width
- RELU_EN, 1, 1 = clamp negative outputs to 0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wt_load  in  1  write weight[wt_row][wt_col] = wt_data
- bias_load  in  1  write bias[wt_row] = wt_data
- wt_row  in  OUT_IDX_W  output index for weight/bias write
- wt_col  in  IN_IDX_W  input index for weight write
- wt_data  in  DATA_W  signed weight/bias value
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts input beat
- in_data  in  DATA_W  signed input element
- in_last  in  1  marks final beat of a frame
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_W  activated output
- out_idx  out  OUT_IDX_W  index of out_data
- out_last  out  1  high with out_idx == OUT_DIM-1
- busy  out  1  frame in progress or draining
- seq_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (sync, rst=1 at posedge):
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, seq_err=0.
  - Internal state: all accumulators, weights and biases cleared to 0; beat counter in_cnt=0; state ACCUM.
  - Reset mid-frame or mid-drain discards all partial results.
- States:
  - ACCUM: in_ready=1.
  - DRAIN: in_ready=0, out_valid=1.
- ACCUM, beat accepted (in_valid & in_ready):
  - For every o: acc[o] += sext_ACC((weight[o][in_cnt] * in_data) >>> FRAC_BITS).
  - Product is full 2*DATA_W signed; the arithmetic shift floors toward negative infinity.
  - The accumulator wraps at ACC_W with no internal saturation.
- Framing:
  - in_cnt increments per accepted beat.
  - Frame completes when the beat with in_cnt == IN_DIM-1 is accepted. The next cycle is DRAIN with out_idx=0, i.e. 1-cycle latency from last input to first out_valid.
  - in_last=0 on the completing beat: frame still completes and seq_err pulses.
  - in_last=1 on a beat with in_cnt < IN_DIM-1: frame aborted, seq_err pulses, accumulators and in_cnt cleared, state stays ACCUM, no output produced.
- Output value: s = acc[idx] + sext(bias[idx]).
  - Saturate to DATA_W signed: above max gives 0x7FFFFFFF; below min gives 0x80000000.
  - Then ReLU if RELU_EN: negative gives 0.
  - out_data is registered and valid when out_valid=1.
- DRAIN:
  - out_data, out_idx and out_last are held stable while out_valid & !out_ready.
  - On handshake, out_idx advances and the next value is presented the following cycle (no bubble).
  - On the handshake with out_idx == OUT_DIM-1: next cycle state=ACCUM, in_ready=1, out_valid=0, accumulators and in_cnt cleared.
- busy = (in_cnt != 0) | DRAIN.
- Weight/bias load:
  - Honoured only when busy=0; ignored otherwise. No seq_err is raised for an ignored write.
  - A write takes effect for beats accepted on the following cycle or later.
  - wt_load and bias_load together: both writes performed.
  - Out-of-range wt_row/wt_col: write ignored.
- A load and an accepted input beat in the same cycle with busy=0: the input beat uses the old weights.

Test Plan:
- Basic forward (IN_DIM=4, OUT_DIM=3, RELU_EN=0): load weight row0=1.0 (0x00010000), row1=0.5 (0x00008000), row2=-1.0 (0xFFFF0000), bias1=0.25 (0x00004000); send 1.0, 2.0, 3.0, 4.0 with in_last on beat 4 -> out_valid 1 cycle later; outputs 0x000A0000, 0x00054000, 0xFFF60000 at idx 0/1/2; out_last only on idx 2.
- ReLU: same as the basic forward test with RELU_EN=1 -> idx2 out_data=0x00000000; idx0/1 unchanged.
- Backpressure: hold out_ready=0 for 5 cycles at idx1 -> out_data stays 0x00054000, out_idx=1, in_ready=0 throughout; after release, idx2 is presented the next cycle.
- Saturation: all weights 0x7FFF0000, inputs 4x 0x7FFF0000 -> out_data=0x7FFFFFFF; negate inputs with RELU_EN=0 -> 0x80000000.
- Framing error: in_last on beat 2 -> seq_err one-cycle pulse, no out_valid; the following correct frame gives the basic-forward results exactly.
- Reset/loads: wt_load during beat 2 of a frame -> ignored and results unchanged; rst asserted mid-DRAIN -> next cycle out_valid=0, in_ready=1, busy=0; the next frame then outputs 0x00000000 for all idx (weights cleared).
